// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM encoding, ASCII constants and the
// ITU letter/digit lookup table used by both decoder and encoder.
package morse_pkg;

    typedef enum logic [1:0] {
        COLLECT    = 2'd0,
        EMIT       = 2'd1,
        EMIT_SPACE = 2'd2
    } state_t;

    localparam logic [6:0] ASCII_SPACE     = 7'h20;
    localparam logic [6:0] DEFAULT_UNKNOWN = 7'h3F;
    localparam int unsigned LUT_MAX_LEN    = 5;

    typedef struct packed {
        logic       hit;
        logic [6:0] ascii;
    } lookup_t;

    // Key is {len, pattern}; pattern bit 0 is the first element, 1 = dash.
    function automatic lookup_t morse_lookup(
        input logic [2:0] len,
        input logic [4:0] pattern
    );
        lookup_t r;
        r.hit   = 1'b1;
        r.ascii = 7'h00;
        case ({len, pattern})
            8'b001_00000: r.ascii = 7'h45;
            8'b001_00001: r.ascii = 7'h54;
            8'b010_00010: r.ascii = 7'h41;
            8'b010_00000: r.ascii = 7'h49;
            8'b010_00011: r.ascii = 7'h4D;
            8'b010_00001: r.ascii = 7'h4E;
            8'b011_00001: r.ascii = 7'h44;
            8'b011_00011: r.ascii = 7'h47;
            8'b011_00101: r.ascii = 7'h4B;
            8'b011_00111: r.ascii = 7'h4F;
            8'b011_00010: r.ascii = 7'h52;
            8'b011_00000: r.ascii = 7'h53;
            8'b011_00100: r.ascii = 7'h55;
            8'b011_00110: r.ascii = 7'h57;
            8'b100_00001: r.ascii = 7'h42;
            8'b100_00101: r.ascii = 7'h43;
            8'b100_00100: r.ascii = 7'h46;
            8'b100_00000: r.ascii = 7'h48;
            8'b100_01110: r.ascii = 7'h4A;
            8'b100_00010: r.ascii = 7'h4C;
            8'b100_00110: r.ascii = 7'h50;
            8'b100_01011: r.ascii = 7'h51;
            8'b100_01000: r.ascii = 7'h56;
            8'b100_01001: r.ascii = 7'h58;
            8'b100_01101: r.ascii = 7'h59;
            8'b100_00011: r.ascii = 7'h5A;
            8'b101_11111: r.ascii = 7'h30;
            8'b101_11110: r.ascii = 7'h31;
            8'b101_11100: r.ascii = 7'h32;
            8'b101_11000: r.ascii = 7'h33;
            8'b101_10000: r.ascii = 7'h34;
            8'b101_00000: r.ascii = 7'h35;
            8'b101_00001: r.ascii = 7'h36;
            8'b101_00011: r.ascii = 7'h37;
            8'b101_00111: r.ascii = 7'h38;
            8'b101_01111: r.ascii = 7'h39;
            default:      r.hit   = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only
// when a pop happens on the same edge.
module morse_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/morse_stream_decoder.sv
// Morse element stream to ASCII: element shift register, close/emit FSM,
// space suppression and a buffered valid/ready output with overflow flag.
module morse_stream_decoder
    import morse_pkg::*;
#(
    parameter int         MAX_ELEMENTS = 6,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [6:0] UNKNOWN_CHAR = DEFAULT_UNKNOWN
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            elemValid,
    input  logic                            elemDash,
    input  logic                            charEnd,
    input  logic                            wordEnd,
    output logic                            elemReady,
    output logic [6:0]                      ascii,
    output logic                            asciiValid,
    input  logic                            asciiReady,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifoCount,
    output logic                            codeError,
    output logic                            overflow
);

    localparam int LEN_W = $clog2(MAX_ELEMENTS + 1);

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [MAX_ELEMENTS-1:0] pattern_q, pattern_d;
    logic                    overlong_q, overlong_d;
    logic                    word_pend_q, word_pend_d;
    logic                    last_space_q, last_space_d;
    logic                    overflow_q, overflow_d;

    logic       wr_en;
    logic [6:0] wr_data;
    logic       code_err;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    lookup_t    lut;
    logic       lut_hit;

    assign pop = asciiValid && asciiReady;
    assign lut = morse_lookup(len_q[2:0], pattern_q[4:0]);

    // Codes longer than the table can never hit, whatever the low bits say.
    assign lut_hit = lut.hit && !overlong_q &&
                     (len_q <= LEN_W'(LUT_MAX_LEN));

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        pattern_d    = pattern_q;
        overlong_d   = overlong_q;
        word_pend_d  = word_pend_q;
        last_space_d = last_space_q;
        wr_en        = 1'b0;
        wr_data      = 7'h00;
        code_err     = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (elemValid) begin
                    if (len_q == LEN_W'(MAX_ELEMENTS)) begin
                        overlong_d = 1'b1;
                    end else begin
                        pattern_d[len_q] = elemDash;
                        len_d            = len_q + 1'b1;
                    end
                end
                if (wordEnd) begin
                    word_pend_d = 1'b1;
                    state_d     = (len_d != '0) ? EMIT : EMIT_SPACE;
                end else if (charEnd && (len_d != '0)) begin
                    word_pend_d = 1'b0;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                wr_en        = 1'b1;
                wr_data      = lut_hit ? lut.ascii : UNKNOWN_CHAR;
                code_err     = !lut_hit;
                last_space_d = (wr_data == ASCII_SPACE);
                len_d        = '0;
                pattern_d    = '0;
                overlong_d   = 1'b0;
                word_pend_d  = 1'b0;
                state_d      = word_pend_q ? EMIT_SPACE : COLLECT;
            end
            EMIT_SPACE: begin
                if (!last_space_q) begin
                    wr_en        = 1'b1;
                    wr_data      = ASCII_SPACE;
                    last_space_d = 1'b1;
                end
                word_pend_d = 1'b0;
                state_d     = COLLECT;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
        overflow_d = overflow_q | (wr_en & fifo_full & ~pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= COLLECT;
            len_q        <= '0;
            pattern_q    <= '0;
            overlong_q   <= 1'b0;
            word_pend_q  <= 1'b0;
            last_space_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            pattern_q    <= pattern_d;
            overlong_q   <= overlong_d;
            word_pend_q  <= word_pend_d;
            last_space_q <= last_space_d;
            overflow_q   <= overflow_d;
        end
    end

    assign elemReady  = (state_q == COLLECT);
    assign codeError  = code_err;
    assign overflow   = overflow_q;
    assign asciiValid = !fifo_empty;

    morse_fifo #(
        .WIDTH (7),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (wr_en),
        .din   (wr_data),
        .pop   (asciiReady),
        .dout  (ascii),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifoCount)
    );

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Scoreboard bench: expected characters queued as codes are sent,
// compared when the consumer pops them.
module tb_morse_stream_decoder;

    logic       clock;
    logic       reset;
    logic       elemValid;
    logic       elemDash;
    logic       charEnd;
    logic       wordEnd;
    logic       elemReady;
    logic [6:0] ascii;
    logic       asciiValid;
    logic       asciiReady;
    logic [3:0] fifoCount;
    logic       codeError;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    logic [6:0] sb[$];

    morse_stream_decoder dut (
        .clock      (clock),
        .reset      (reset),
        .elemValid  (elemValid),
        .elemDash   (elemDash),
        .charEnd    (charEnd),
        .wordEnd    (wordEnd),
        .elemReady  (elemReady),
        .ascii      (ascii),
        .asciiValid (asciiValid),
        .asciiReady (asciiReady),
        .fifoCount  (fifoCount),
        .codeError  (codeError),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic d,
                         input logic ce, input logic we);
        int n = 0;
        while (!elemReady && n < 20) begin
            step();
            n++;
        end
        if (!elemReady) check("ready_timeout", elemReady, 1);
        elemValid = v;
        elemDash  = d;
        charEnd   = ce;
        wordEnd   = we;
        step();
        elemValid = 1'b0;
        elemDash  = 1'b0;
        charEnd   = 1'b0;
        wordEnd   = 1'b0;
    endtask

    task automatic send_code(input string code, input bit word,
                             input bit merge, input logic [6:0] exp,
                             input bit exp_push);
        int n = code.len();
        for (int i = 0; i < n; i++) begin
            if (merge && i == n - 1)
                drive(1'b1, code[i] == "-", !word, word);
            else
                drive(1'b1, code[i] == "-", 1'b0, 1'b0);
        end
        if (!merge) drive(1'b0, 1'b0, !word, word);
        if (exp_push) sb.push_back(exp);
    endtask

    task automatic drain();
        int n = 0;
        asciiReady = 1'b1;
        while ((fifoCount != 0 || sb.size() != 0) && n < 100) begin
            step();
            n++;
        end
        check("drain_count", 32'(fifoCount), 0);
        check("drain_sb", sb.size(), 0);
    endtask

    always @(negedge clock) begin
        if (!reset && asciiValid && asciiReady) begin
            if (sb.size() == 0)
                check("unexpected_pop", asciiValid, 0);
            else
                check("pop_data", ascii, sb.pop_front());
        end
    end

    initial begin
        reset      = 1'b1;
        elemValid  = 1'b0;
        elemDash   = 1'b0;
        charEnd    = 1'b0;
        wordEnd    = 1'b0;
        asciiReady = 1'b1;
        #12;
        reset = 1'b0;
        step();
        check("rst_ready", elemReady, 1);
        check("rst_valid", asciiValid, 0);
        check("rst_ascii", ascii, 7'h00);
        check("rst_count", 32'(fifoCount), 0);
        check("rst_cerr", codeError, 0);
        check("rst_ovf", overflow, 0);

        // ".-" -> 'A'
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        sb.push_back(7'h41);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("a_emit_valid", asciiValid, 0);
        check("a_emit_ready", elemReady, 0);
        step();
        check("a_valid", asciiValid, 1);
        check("a_ascii", ascii, 7'h41);
        check("a_count", 32'(fifoCount), 1);
        step();
        check("a_popped", 32'(fifoCount), 0);

        // "-----" + wordEnd -> '0', ' '
        asciiReady = 1'b0;
        send_code("-----", 1'b1, 1'b0, 7'h30, 1'b1);
        sb.push_back(7'h20);
        check("w_ready0", elemReady, 0);
        step();
        check("w_ready1", elemReady, 0);
        step();
        check("w_ready2", elemReady, 1);
        check("w_count", 32'(fifoCount), 2);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        step();
        check("w_dup_space", 32'(fifoCount), 2);
        drain();

        // seven dots -> UNKNOWN_CHAR, then 'E'
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        sb.push_back(7'h3F);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("ol_cerr_hi", codeError, 1);
        step();
        check("ol_cerr_lo", codeError, 0);
        send_code(".", 1'b0, 1'b0, 7'h45, 1'b1);
        step();
        check("e_cerr", codeError, 0);
        drain();

        // fill FIFO, simultaneous write/pop when full, then overflow
        asciiReady = 1'b0;
        send_code(".", 1'b0, 1'b0, 7'h45, 1'b1);
        send_code("-", 1'b0, 1'b0, 7'h54, 1'b1);
        send_code("..", 1'b0, 1'b0, 7'h49, 1'b1);
        send_code(".-", 1'b0, 1'b1, 7'h41, 1'b1);
        send_code("-.", 1'b0, 1'b0, 7'h4E, 1'b1);
        send_code("--", 1'b0, 1'b0, 7'h4D, 1'b1);
        send_code("...", 1'b0, 1'b0, 7'h53, 1'b1);
        send_code("..-", 1'b0, 1'b0, 7'h55, 1'b1);
        step();
        check("full_count", 32'(fifoCount), 8);
        check("full_ovf", overflow, 0);
        send_code(".-.", 1'b0, 1'b0, 7'h52, 1'b1);
        asciiReady = 1'b1;
        step();
        asciiReady = 1'b0;
        check("pw_count", 32'(fifoCount), 8);
        check("pw_ovf", overflow, 0);
        send_code("---", 1'b0, 1'b0, 7'h4F, 1'b0);
        step();
        check("ovf_count", 32'(fifoCount), 8);
        check("ovf_set", overflow, 1);
        drain();
        check("ovf_sticky", overflow, 1);

        // reset mid-character
        asciiReady = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        sb.delete();
        check("rc_ready", elemReady, 1);
        check("rc_valid", asciiValid, 0);
        check("rc_count", 32'(fifoCount), 0);
        check("rc_ovf", overflow, 0);
        check("rc_ascii", ascii, 7'h00);
        reset = 1'b0;
        step();

        // reset mid-EMIT with a character already buffered
        send_code(".", 1'b0, 1'b0, 7'h45, 1'b0);
        step();
        check("re_pre_count", 32'(fifoCount), 1);
        send_code("-.-", 1'b0, 1'b0, 7'h4B, 1'b0);
        check("re_in_emit", elemReady, 0);
        reset = 1'b1;
        #2;
        check("re_ready", elemReady, 1);
        check("re_cerr", codeError, 0);
        check("re_count", 32'(fifoCount), 0);
        check("re_valid", asciiValid, 0);
        check("re_ascii", ascii, 7'h00);
        reset = 1'b0;
        step();

        // clean decode after reset, last element merged with charEnd
        asciiReady = 1'b1;
        send_code("-.-", 1'b0, 1'b1, 7'h4B, 1'b1);
        step();
        check("k_cerr", codeError, 0);
        drain();
        check("end_ovf", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_stream_decoder.md
# morse_stream_decoder

Parametrised successor to the fixed 6-bit-index Morse-to-ASCII converter. It accepts a raw element stream (dot/dash plus character and word boundaries) from the key-timing front end. It assembles each character in a shift register, translates it to 7-bit ASCII, and buffers the results in an output FIFO with a valid/ready handshake to the display/UART side. It adds overlength/unknown-code detection, word-space insertion and overflow reporting.

## Interface
- MAX_ELEMENTS, 6: max dots/dashes per character (≥5; 6 covers punctuation-length codes).
- FIFO_DEPTH, 8: output FIFO entries, power of two, ≥2.
- UNKNOWN_CHAR, 7'h3F: ASCII emitted for undecodable or overlength codes.
- clock  in  1: system clock (50 MHz).
- reset  in  1: asynchronous, active-high.
- elemValid  in  1: one element offered this cycle.
- elemDash  in  1: 1 = dash, 0 = dot; qualified by elemValid.
- charEnd  in  1: close current character (qualified by elemReady).
- wordEnd  in  1: close current character and append a space.
- elemReady  out  1: decoder accepts elemValid/charEnd/wordEnd this cycle.
- ascii  out  7: FIFO head character.
- asciiValid  out  1: FIFO non-empty.
- asciiReady  in  1: consumer pops head when asciiValid && asciiReady.
- fifoCount  out  $clog2(FIFO_DEPTH+1): entries held.
- codeError  out  1: one-cycle pulse when UNKNOWN_CHAR is written.
- overflow  out  1: sticky; a write was dropped because FIFO was full. Cleared only by reset.

## Operation
- States: COLLECT, EMIT, EMIT_SPACE. elemReady = (state == COLLECT). Inputs are ignored when elemReady is low; the producer holds them.
- COLLECT, elemValid: pattern[len] <= elemDash (bit 0 = first element), len++. At len == MAX_ELEMENTS, set overlong, keep len and pattern.
- Same-cycle elemValid with charEnd/wordEnd: element is included, then the character is closed.
- charEnd with len>0 → EMIT. wordEnd with len>0 → EMIT, then EMIT_SPACE. wordEnd with len==0 → EMIT_SPACE. charEnd with len==0 → no action.
- EMIT: write lookup(len, pattern), or UNKNOWN_CHAR if overlong or unmapped. Clear len/pattern/overlong. Go to EMIT_SPACE if a word end is pending, else COLLECT.
- EMIT_SPACE: write 7'h20 unless the last written character was a space (suppresses repeated spaces). → COLLECT.
- Lookup covers A–Z (7'h41–5A) and 0–9 (7'h30–39) per ITU codes. All other (len, pattern) combinations are unmapped.
- FIFO write when full and no same-cycle pop: data dropped, overflow <= 1. codeError still pulses if applicable.
- Write and pop in the same cycle while full: both succeed, count unchanged.

## Timing
- Reset values: state COLLECT, len 0, elemReady 1, asciiValid 0, ascii 7'h00, fifoCount 0, codeError 0, overflow 0, last-was-space 0.
- Reset is asynchronous. Mid-character or mid-EMIT reset discards everything, including FIFO contents.
- Latency: charEnd accepted at edge N → EMIT during N+1 → FIFO write at edge N+2. asciiValid is high from N+2 if the FIFO was empty.
- wordEnd after a character: char written at N+2, space at N+3. elemReady is low for 2 cycles.
- Pop: head advances on the edge where asciiValid && asciiReady. ascii is show-ahead, registered, and changes only on write-to-empty or pop.
- codeError is high during the EMIT cycle that writes UNKNOWN_CHAR.
- fifoCount updates on the same edge as the write/pop.

## Structure
- Package morse_pkg: state encoding, ASCII_SPACE 7'h20, default UNKNOWN_CHAR, and the lookup function (len, pattern) → {hit, ascii}. The table is shared with the encoder block.
- Sub-module morse_fifo: synchronous show-ahead FIFO, parametrised WIDTH/DEPTH, with full/empty/count and simultaneous push/pop when full.
- Top: element shift register, length counter, FSM, last-was-space flag, overflow register.

## Test plan
- Dot, dash, charEnd (".-") with asciiReady=1 → ascii 7'h41 ('A') valid 2 cycles after charEnd, popped next edge, fifoCount back to 0.
- "-----" then wordEnd → FIFO holds 7'h30, 7'h20. A second wordEnd with len 0 writes nothing more.
- 7 dots then charEnd (MAX_ELEMENTS 6) → 7'h3F written, codeError high exactly 1 cycle. Next ". " decodes to 7'h45 ('E').
- asciiReady=0, write 9 characters into FIFO_DEPTH 8 → fifoCount 8, overflow 1 after the 9th, first 8 read out in order.
- Full FIFO with asciiReady=1 on the same cycle as a write → no overflow, fifoCount stays 8.
- Assert reset mid-character (after "-.") and mid-EMIT → all outputs return to reset values immediately. The next "-.-" yields 7'h4B ('K') with no residue.
